// File: rtl/alu_result_reader.sv
// alu_result_reader
//   Read-back side of the switch-entered ALU datapath. Captures a 32-bit ALU
//   result plus its Z/O/C/N flags on a one-cycle strobe. The result is shown
//   on HEX3..HEX0 in two 16-bit pages (low/high). HEX4 shows the page letter
//   (L/H) and HEX5 shows the flags. KEY inputs are synchronized and debounced.
//
// Ports
//   CLOCK_50      system clock, rising edge
//   reset         asynchronous, active-high
//   result        ALU result bus (sampled only when result_valid=1)
//   z, o, c, n    ALU zero/overflow/carry/negative flags
//   result_valid  single-cycle capture strobe
//   page_n        raw KEY, active-low: a press toggles the page
//   clear_n       raw KEY, active-low: a press blanks the display
//   HEX0..HEX5    active-low segments {g,f,e,d,c,b,a}, registered
//   page_hi       1 = result[31:16] displayed
//   loaded        1 = a captured value is held
//
// Build option
//   AUTO_PAGE_EN  when defined, the page also toggles every PAGE_CYCLES
//                 cycles while a value is shown.

module alu_result_debounce #(
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic CLOCK_50,
    input  logic reset,
    input  logic key_n,
    output logic press
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic [1:0]    sync;
    logic          level;   // accepted level, 1 = released
    logic          armed;   // set once a stable release has been seen
    logic [CW-1:0] cnt;
    logic          last;

    assign last = (cnt == CW'(DEBOUNCE_CYCLES - 1));

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            sync  <= 2'b11;
            level <= 1'b1;
            armed <= 1'b0;
            cnt   <= '0;
        end else begin
            sync <= {sync[0], key_n};
            if (!armed) begin
                // A key held through reset must be seen released before it
                // can produce a press.
                if (!sync[1])  cnt <= '0;
                else if (last) begin
                    armed <= 1'b1;
                    cnt   <= '0;
                end else       cnt <= cnt + CW'(1);
            end else if (sync[1] == level) begin
                cnt <= '0;
            end else if (last) begin
                level <= sync[1];
                cnt   <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

    // Pulses in the cycle the accepted level falls 1->0.
    assign press = armed & level & ~sync[1] & last;
endmodule

module alu_result_reader #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int PAGE_CYCLES     = 25000000
) (
    input  logic        CLOCK_50,
    input  logic        reset,
    input  logic [31:0] result,
    input  logic        z,
    input  logic        o,
    input  logic        c,
    input  logic        n,
    input  logic        result_valid,
    input  logic        page_n,
    input  logic        clear_n,
    output logic [6:0]  HEX0,
    output logic [6:0]  HEX1,
    output logic [6:0]  HEX2,
    output logic [6:0]  HEX3,
    output logic [6:0]  HEX4,
    output logic [6:0]  HEX5,
    output logic        page_hi,
    output logic        loaded
);
    if (DEBOUNCE_CYCLES < 3) $error("DEBOUNCE_CYCLES must be at least 3");
    if (PAGE_CYCLES < 1)     $error("PAGE_CYCLES must be at least 1");

    typedef enum logic [1:0] {EMPTY, SHOW_LO, SHOW_HI} state_t;

    localparam logic [6:0] BLANK = 7'h7F;
    localparam logic [6:0] SEG_L = 7'b1000111;
    localparam logic [6:0] SEG_H = 7'b0001001;

    function automatic logic [6:0] seg7(input logic [3:0] v);
        case (v)
            4'h0: seg7 = 7'b1000000;  4'h1: seg7 = 7'b1111001;
            4'h2: seg7 = 7'b0100100;  4'h3: seg7 = 7'b0110000;
            4'h4: seg7 = 7'b0011001;  4'h5: seg7 = 7'b0010010;
            4'h6: seg7 = 7'b0000010;  4'h7: seg7 = 7'b1111000;
            4'h8: seg7 = 7'b0000000;  4'h9: seg7 = 7'b0010000;
            4'hA: seg7 = 7'b0001000;  4'hB: seg7 = 7'b0000011;
            4'hC: seg7 = 7'b1000110;  4'hD: seg7 = 7'b0100001;
            4'hE: seg7 = 7'b0000110;  default: seg7 = 7'b0001110;
        endcase
    endfunction

    // Key 0 = page, key 1 = clear.
    logic [1:0] key_raw;
    logic [1:0] key_press;
    assign key_raw = {clear_n, page_n};

    alu_result_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db [1:0] (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .key_n    (key_raw),
        .press    (key_press)
    );

    state_t      state, state_nxt;
    logic        cap_en;
    logic        page_evt;
    logic        clr_evt;
    logic [31:0] cap_val;
    logic [3:0]  cap_flags;   // {z,o,c,n}

    assign clr_evt = key_press[1];

`ifdef AUTO_PAGE_EN
    logic [31:0] page_cnt;
    logic        auto_tick;

    assign auto_tick = (state != EMPTY) && (page_cnt == 32'(PAGE_CYCLES - 1));
    assign page_evt  = key_press[0] | auto_tick;

    // Any page change, capture or trip through EMPTY restarts the interval.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset)
            page_cnt <= '0;
        else if (state == EMPTY || state_nxt == EMPTY || cap_en || page_evt)
            page_cnt <= '0;
        else
            page_cnt <= page_cnt + 32'd1;
    end
`else
    assign page_evt = key_press[0];
`endif

    always_comb begin
        state_nxt = state;
        cap_en    = 1'b0;
        case (state)
            EMPTY: begin
                if (result_valid) begin
                    cap_en    = 1'b1;
                    state_nxt = SHOW_LO;
                end
            end
            default: begin
                // clear > result_valid > page; losers are dropped.
                if (clr_evt) begin
                    state_nxt = EMPTY;
                end else if (result_valid) begin
                    cap_en    = 1'b1;
                    state_nxt = SHOW_LO;
                end else if (page_evt) begin
                    state_nxt = (state == SHOW_LO) ? SHOW_HI : SHOW_LO;
                end
            end
        endcase
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state     <= EMPTY;
            cap_val   <= '0;
            cap_flags <= '0;
        end else begin
            state <= state_nxt;
            if (cap_en) begin
                cap_val   <= result;
                cap_flags <= {z, o, c, n};
            end
        end
    end

    // Display decode, registered one edge behind state/capture.
    logic [15:0]     digits;
    logic [5:0][6:0] hex_d, hex_q;

    assign digits = (state == SHOW_HI) ? cap_val[31:16] : cap_val[15:0];

    always_comb begin
        hex_d = {6{BLANK}};
        if (state != EMPTY) begin
            for (int i = 0; i < 4; i++)
                hex_d[i] = seg7(digits[i*4 +: 4]);
            hex_d[4] = (state == SHOW_HI) ? SEG_H : SEG_L;
            // Flag segments light when set: a=Z, g=O, d=C, f=N.
            hex_d[5][0] = ~cap_flags[3];
            hex_d[5][6] = ~cap_flags[2];
            hex_d[5][3] = ~cap_flags[1];
            hex_d[5][5] = ~cap_flags[0];
        end
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            hex_q   <= {6{BLANK}};
            page_hi <= 1'b0;
            loaded  <= 1'b0;
        end else begin
            hex_q   <= hex_d;
            page_hi <= (state == SHOW_HI);
            loaded  <= (state != EMPTY);
        end
    end

    assign HEX0 = hex_q[0];
    assign HEX1 = hex_q[1];
    assign HEX2 = hex_q[2];
    assign HEX3 = hex_q[3];
    assign HEX4 = hex_q[4];
    assign HEX5 = hex_q[5];
endmodule

// File: tb/tb_alu_result_reader.sv
module tb_alu_result_reader;
    localparam int DB = 4;
    localparam int PC = 8;

    logic        CLOCK_50 = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] result = '0;
    logic        z = 0, o = 0, c = 0, n = 0;
    logic        result_valid = 1'b0;
    logic        page_n = 1'b1, clear_n = 1'b1;
    logic [6:0]  HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;
    logic        page_hi, loaded;

    alu_result_reader #(.DEBOUNCE_CYCLES(DB), .PAGE_CYCLES(PC)) dut (
        .CLOCK_50(CLOCK_50), .reset(reset), .result(result),
        .z(z), .o(o), .c(c), .n(n), .result_valid(result_valid),
        .page_n(page_n), .clear_n(clear_n),
        .HEX0(HEX0), .HEX1(HEX1), .HEX2(HEX2), .HEX3(HEX3), .HEX4(HEX4), .HEX5(HEX5),
        .page_hi(page_hi), .loaded(loaded)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: what the display should show.
    bit          m_loaded = 0;
    bit          m_hi = 0;
    logic [31:0] m_val = '0;
    logic [3:0]  m_flags = '0;   // {z,o,c,n}

    logic [6:0] SEG [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                             7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                             7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                             7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

    task automatic tick(input int cycles);
        repeat (cycles) @(posedge CLOCK_50);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_model(input string tag);
        logic [6:0]  e [6];
        logic [15:0] half;
        if (!m_loaded) begin
            for (int i = 0; i < 6; i++) e[i] = 7'h7F;
        end else begin
            half = m_hi ? m_val[31:16] : m_val[15:0];
            e[0] = SEG[half[3:0]];
            e[1] = SEG[half[7:4]];
            e[2] = SEG[half[11:8]];
            e[3] = SEG[half[15:12]];
            e[4] = m_hi ? 7'b0001001 : 7'b1000111;
            e[5] = 7'h7F;
            if (m_flags[3]) e[5][0] = 1'b0;
            if (m_flags[2]) e[5][6] = 1'b0;
            if (m_flags[1]) e[5][3] = 1'b0;
            if (m_flags[0]) e[5][5] = 1'b0;
        end
        chk({tag, "/hex0"}, 32'(HEX0), 32'(e[0]));
        chk({tag, "/hex1"}, 32'(HEX1), 32'(e[1]));
        chk({tag, "/hex2"}, 32'(HEX2), 32'(e[2]));
        chk({tag, "/hex3"}, 32'(HEX3), 32'(e[3]));
        chk({tag, "/hex4"}, 32'(HEX4), 32'(e[4]));
        chk({tag, "/hex5"}, 32'(HEX5), 32'(e[5]));
        chk({tag, "/loaded"}, 32'(loaded), 32'(m_loaded));
        chk({tag, "/page_hi"}, 32'(page_hi), 32'(m_loaded && m_hi));
    endtask

    // Strobe for one cycle, then wait for the registered display.
    task automatic capture(input logic [31:0] val, input logic [3:0] fl);
        result = val;
        {z, o, c, n} = fl;
        result_valid = 1'b1;
        tick(1);
        result_valid = 1'b0;
        result = $urandom;
        {z, o, c, n} = 4'($urandom);
        tick(1);
        m_loaded = 1; m_hi = 0; m_val = val; m_flags = fl;
    endtask

    task automatic press_page();
        page_n = 1'b0; tick(10);
        page_n = 1'b1; tick(10);
        if (m_loaded) m_hi = !m_hi;
    endtask

    task automatic press_clear();
        clear_n = 1'b0; tick(10);
        clear_n = 1'b1; tick(10);
        m_loaded = 0; m_hi = 0;
    endtask

    initial begin
        tick(3);
        check_model("reset_held");
        reset = 1'b0;
        tick(12);
        check_model("idle");
`ifndef AUTO_PAGE_EN
        press_page();
        check_model("page_in_empty");
        press_clear();
        check_model("clear_in_empty");

        capture(32'hABCD_0123, 4'b0110);
        check_model("cap1");
        chk("cap1/hex5_lit", 32'(HEX5), 32'(7'b0110111));
        chk("cap1/hex0_3", 32'(HEX0), 32'(7'b0110000));
        press_page();
        check_model("page_hi");
        chk("page_hi/hex3_A", 32'(HEX3), 32'(7'b0001000));
        press_page();
        check_model("page_lo");

        page_n = 1'b0; tick(2);
        page_n = 1'b1; tick(12);
        check_model("glitch");

        for (int i = 0; i < 6; i++) begin
            capture($urandom, 4'($urandom));
            check_model("rand_cap");
            if ($urandom_range(0, 1) == 1) press_page();
            check_model("rand_page");
        end

        press_clear();
        check_model("clear");

        // Clear, page and strobe all land on the same edge: clear wins.
        capture($urandom, 4'($urandom));
        clear_n = 1'b0; page_n = 1'b0;
        tick(DB + 1);
        result = 32'h0000_FFFF;
        result_valid = 1'b1;
        tick(1);
        result_valid = 1'b0;
        tick(1);
        m_loaded = 0; m_hi = 0;
        check_model("coincide");
        clear_n = 1'b1; page_n = 1'b1;
        tick(12);
        check_model("coincide_release");

        capture($urandom, 4'($urandom));
        press_page();
        check_model("pre_recap_hi");
        capture(32'h0000_FFFF, 4'b1001);
        check_model("recap_from_hi");

        reset = 1'b1; tick(1);
        m_loaded = 0; m_hi = 0;
        check_model("reset_mid_show");

        // Key held across reset release must not produce a page event.
        page_n = 1'b0; tick(3);
        tick(3);
        reset = 1'b0;
        capture(32'h1234_5678, 4'b0001);
        tick(10);
        check_model("held_key");
        page_n = 1'b1; tick(12);
        check_model("held_key_release");
        press_page();
        check_model("after_held_press");
`else
        capture($urandom, 4'($urandom));
        check_model("auto_cap");
        tick(7);
        check_model("auto_before");
        tick(1);
        m_hi = 1;
        check_model("auto_hi");
        tick(8);
        m_hi = 0;
        check_model("auto_lo");
        tick(3);
        reset = 1'b1; tick(1);
        m_loaded = 0; m_hi = 0;
        check_model("auto_reset");
        reset = 1'b0; tick(2);
        capture($urandom, 4'($urandom));
        tick(7);
        check_model("auto_restart_lo");
        tick(1);
        m_hi = 1;
        check_model("auto_restart_hi");
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
